acc: RTL and testbench
======================

Name: acc

Overview:
- 16-bit accumulator register for the BIP processor datapath.
- Captures the ALU/operand bus value on a clock edge when write-enabled.
- Holds the value otherwise and drives it continuously back to the ALU and data memory.
- Asynchronous Clear returns the accumulator to zero; two status flags are derived from the stored value.

Parameters:
- WIDTH, 16, data width of Entrada, Salida and the internal register.

Ports:
- clk  input  1  system clock; all captures on rising edge.
- Clear  input  1  asynchronous, active-high reset; forces accumulator to zero.
- Entrada  input  WIDTH  data to be loaded into the accumulator.
- WrAcc  input  1  write enable; load Entrada on the next rising clk edge when high.
- Salida  output  WIDTH  current accumulator contents, registered.
- Zero  output  1  high when Salida == 0 (combinational from the register).
- Neg  output  1  equals Salida[WIDTH-1], the sign bit (combinational from the register).

Interface (already decided):
- One clock; reset is asynchronous and active-high.
- Clock port is clk; reset port is Clear.

Behaviour:
- Storage: single WIDTH-bit register; Salida is the register output directly, with no combinational path from Entrada.
- Reset value: register = 0, so Salida = 0x0000, Zero = 1, Neg = 0.
- Clear asserted:
  - Register clears immediately, with no clock edge needed.
  - Register stays 0 for as long as Clear is high, regardless of clk, WrAcc or Entrada.
- Priority: Clear overrides WrAcc. If Clear and WrAcc are high at the same edge, the result is 0.
- Clear deassert: the first rising edge with Clear = 0 and WrAcc = 1 loads Entrada. Deassertion is assumed synchronised upstream; the block adds no synchronizer.
- Load:
  - On rising clk with Clear = 0 and WrAcc = 1, register <= Entrada.
  - New value is visible on Salida after that edge (latency 1 clock).
  - Entrada is sampled only at the edge. Changes between edges do not affect Salida.
- Hold: on rising clk with Clear = 0 and WrAcc = 0, register keeps its value indefinitely.
- Arithmetic: none inside the block. Value is stored bit-exact (no sign extension, truncation or saturation); all 16 bits are significant.
- Flags:
  - Zero and Neg update with the register: after each load edge, and immediately on Clear.
  - Both are glitch-free relative to the register output.
- X handling: WrAcc = X or Entrada = X at a load edge may corrupt the register. Clear always recovers to 0.
- No handshake and no internal state beyond the data register.

Test Plan:
- Power-up reset: hold Clear = 1, Entrada = 0, WrAcc = 0 for several edges -> Salida = 0x0000, Zero = 1, Neg = 0.
- Sequential loads: Clear = 0, WrAcc = 1.
  - Entrada = 0xC33F, edge -> Salida = 0xC33F, Neg = 1, Zero = 0.
  - Entrada = 0x1320, edge -> Salida = 0x1320, Neg = 0.
  - Entrada = 0x0007, edge -> Salida = 0x0007.
  - Between edges, changing Entrada leaves Salida unchanged.
- Hold: Salida = 0x0007, set WrAcc = 0 and Entrada = 0xFFFF over 3 edges -> Salida remains 0x0007.
- Asynchronous clear: Salida = 0x0007, raise Clear mid-low-phase of clk with no edge -> Salida = 0x0000 at once. Next edge with WrAcc = 1, Entrada = 0xFFFF -> Salida stays 0x0000.
- Recovery: drop Clear, WrAcc = 1, Entrada = 0x8000, edge -> Salida = 0x8000, Neg = 1. Then Entrada = 0x0000, edge -> Salida = 0x0000, Zero = 1.

Source files
------------

// File: rtl/acc.sv
`default_nettype none
// ============================================================================
//  Module      : acc
//  Description : Accumulator register for the BIP processor datapath.
//                Captures Entrada on a rising clk edge when WrAcc is high,
//                holds its value otherwise, and publishes Zero/Neg status
//                flags derived from the stored value. Clear is asynchronous.
//  Revision    : 1.0 - initial release
// ============================================================================
module acc #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             Clear,
    input  logic [WIDTH-1:0] Entrada,
    input  logic             WrAcc,
    output logic [WIDTH-1:0] Salida,
    output logic             Zero,
    output logic             Neg
);

    // Stored accumulator value; the only state in this block.
    logic [WIDTH-1:0] r_acc;

    // Status flags decoded from the register alone, so they settle together
    // with Salida and never see Entrada directly.
    logic             w_zero;
    logic             w_neg;

    // Accumulator register: Clear wins over any load and acts without a clock
    // edge. Deassertion is expected to be synchronised upstream.
    always_ff @(posedge clk or posedge Clear) begin
        if (Clear) begin
            r_acc <= '0;
        end else if (WrAcc) begin
            r_acc <= Entrada;
        end
    end

    // Flag decode from the registered value.
    always_comb begin
        w_zero = (r_acc == '0);
        w_neg  = r_acc[WIDTH-1];
    end

    assign Salida = r_acc;
    assign Zero   = w_zero;
    assign Neg    = w_neg;

endmodule
`default_nettype wire

// File: tb/tb_acc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acc
//  Description : Self-checking bench for the acc accumulator. Directed steps
//                followed by randomized traffic, compared against a simple
//                behavioural model of the stored value.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_acc;

    localparam int C_WIDTH = 16;

    logic               clk;
    logic               Clear;
    logic [C_WIDTH-1:0] Entrada;
    logic               WrAcc;
    logic [C_WIDTH-1:0] Salida;
    logic               Zero;
    logic               Neg;

    // Reference: the value the accumulator should hold, as a plain integer.
    int unsigned model;

    int n_pass;
    int n_total;
    int n_fail;

    acc #(.WIDTH(C_WIDTH)) dut (
        .clk     (clk),
        .Clear   (Clear),
        .Entrada (Entrada),
        .WrAcc   (WrAcc),
        .Salida  (Salida),
        .Zero    (Zero),
        .Neg     (Neg)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare all outputs against the model; flags derived arithmetically.
    task automatic check_all(input string tag);
        logic [31:0] exp_zero;
        logic [31:0] exp_neg;
        exp_zero = (model == 0) ? 32'd1 : 32'd0;
        exp_neg  = (model >= 32'd32768) ? 32'd1 : 32'd0;
        check_val({tag, ".Salida"}, {16'd0, Salida}, model);
        check_val({tag, ".Zero"},   {31'd0, Zero},   exp_zero);
        check_val({tag, ".Neg"},    {31'd0, Neg},    exp_neg);
    endtask

    // Apply inputs in the low phase; Clear takes effect immediately.
    task automatic drive(input logic c, input logic w, input logic [C_WIDTH-1:0] d);
        @(negedge clk);
        Clear   = c;
        WrAcc   = w;
        Entrada = d;
        if (c) model = 0;
    endtask

    // Advance one rising edge, update the model, sample shortly after.
    task automatic edge_and_check(input string tag);
        @(posedge clk);
        if (!Clear && WrAcc) model = Entrada;
        #1;
        check_all(tag);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        n_fail  = 0;
        model   = 0;
        Clear   = 1'b1;
        WrAcc   = 1'b0;
        Entrada = '0;

        // Power-up reset held over several edges.
        for (int i = 0; i < 3; i++) edge_and_check("reset");

        // Sequential loads.
        drive(1'b0, 1'b1, 16'hC33F);
        edge_and_check("load_C33F");
        drive(1'b0, 1'b1, 16'h1320);
        edge_and_check("load_1320");
        drive(1'b0, 1'b1, 16'h0007);
        edge_and_check("load_0007");

        // Entrada changes between edges must not reach Salida.
        #2 Entrada = 16'hABCD;
        #1 check_all("between_edges");

        // Hold with WrAcc low.
        drive(1'b0, 1'b0, 16'hFFFF);
        for (int i = 0; i < 3; i++) edge_and_check("hold");

        // Asynchronous clear in the middle of the low phase.
        @(negedge clk);
        #2 Clear = 1'b1;
        model = 0;
        #1 check_all("async_clear");
        WrAcc   = 1'b1;
        Entrada = 16'hFFFF;
        edge_and_check("clear_over_write");

        // Recovery after Clear drops.
        drive(1'b0, 1'b1, 16'h8000);
        edge_and_check("recover_8000");
        drive(1'b0, 1'b1, 16'h0000);
        edge_and_check("recover_0000");

        // Randomized traffic: occasional Clear, random enables and data.
        for (int i = 0; i < 300; i++) begin
            logic        rc;
            logic        rw;
            logic [15:0] rd;
            rc = ($urandom_range(0, 9) == 0);
            rw = $urandom_range(0, 1) == 1;
            rd = 16'($urandom);
            if ($urandom_range(0, 7) == 0) rd = 16'h0000;
            drive(rc, rw, rd);
            #1 check_all("rand_pre");
            edge_and_check("rand_edge");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
